// File: rtl/load_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : load_hazard_scoreboard
// Description : Load-use hazard unit that sits beside decode. Each architectural
//               register has a countdown entry that is loaded with LOAD_LATENCY
//               when a load to it issues. The entry falls by one on every
//               pipeline edge that is not frozen. A nonzero entry means the load
//               result cannot yet be forwarded to an ID-stage reader.
//
//               Output priority: reset > memory freeze > taken-branch flush >
//               load-use stall > normal flow.
//
// Ports       : clk             pipeline clock
//               rst_n           synchronous active-low reset
//               id_valid        ID holds a real instruction
//               id_rs1/id_rs2   ID source registers
//               id_uses_rs1/2   instruction actually reads rs1/rs2
//               id_is_load      ID instruction is a load
//               id_rd           ID destination register
//               ex_branch_taken taken branch/jump resolved in EX
//               mem_stall       data memory not ready, whole pipeline frozen
//               pc_write        PC register enable
//               if_id_write     IF/ID register enable
//               id_ex_bubble    load NOP into ID/EX
//               if_id_flush     clear IF/ID to NOP
//               load_use_stall  a load-use stall is in effect this cycle
//               stall_count     saturating count of load-use stall cycles
//
// Revision    : 1.0 - initial release
// ============================================================================
module load_hazard_scoreboard #(
    parameter int NUM_REGS     = 32,
    parameter int REG_AW       = 5,
    parameter int LOAD_LATENCY = 1,
    parameter int PERF_W       = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_uses_rs1,
    input  logic              id_uses_rs2,
    input  logic              id_is_load,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              ex_branch_taken,
    input  logic              mem_stall,
    output logic              pc_write,
    output logic              if_id_write,
    output logic              id_ex_bubble,
    output logic              if_id_flush,
    output logic              load_use_stall,
    output logic [PERF_W-1:0] stall_count
);

    // Counter width is just wide enough to hold LOAD_LATENCY.
    localparam int                 c_CNT_W    = $clog2(LOAD_LATENCY + 1);
    localparam logic [c_CNT_W-1:0] c_LOAD_CNT = c_CNT_W'(LOAD_LATENCY);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [PERF_W-1:0]  c_PERF_MAX = {PERF_W{1'b1}};
    localparam logic [PERF_W-1:0]  c_PERF_ONE = PERF_W'(1);

    // Pipeline control mode for the current cycle, already resolved by priority.
    typedef enum logic [2:0] {
        MODE_RESET  = 3'd0,
        MODE_FREEZE = 3'd1,
        MODE_FLUSH  = 3'd2,
        MODE_HAZARD = 3'd3,
        MODE_NORMAL = 3'd4
    } mode_t;

    logic [c_CNT_W-1:0] r_cnt [NUM_REGS];
    logic [PERF_W-1:0]  r_stall_count;

    logic  w_rs1_busy;
    logic  w_rs2_busy;
    logic  w_hazard;
    logic  w_issue;
    mode_t w_mode;

    // ------------------------------------------------------------------------
    // Hazard detection against the counts as they stand before this edge. A
    // self-dependent load (rd == rs1) therefore sees the older load's count.
    // ------------------------------------------------------------------------
    assign w_rs1_busy = id_uses_rs1 && (id_rs1 != '0) && (r_cnt[id_rs1] != '0);
    assign w_rs2_busy = id_uses_rs2 && (id_rs2 != '0) && (r_cnt[id_rs2] != '0);
    assign w_hazard   = id_valid && (w_rs1_busy || w_rs2_busy);

    always_comb begin
        w_mode = MODE_NORMAL;
        if (!rst_n) begin
            w_mode = MODE_RESET;
        end else if (mem_stall) begin
            w_mode = MODE_FREEZE;
        end else if (ex_branch_taken) begin
            w_mode = MODE_FLUSH;
        end else if (w_hazard) begin
            w_mode = MODE_HAZARD;
        end
    end

    // A load only claims its destination when it really leaves ID. A load
    // that is stalled, flushed or frozen does not claim it. A load to x0
    // never claims its destination.
    assign w_issue = (w_mode == MODE_NORMAL) && id_valid && id_is_load && (id_rd != '0);

    // ------------------------------------------------------------------------
    // Pipeline control outputs
    // ------------------------------------------------------------------------
    always_comb begin
        pc_write       = 1'b1;
        if_id_write    = 1'b1;
        id_ex_bubble   = 1'b0;
        if_id_flush    = 1'b0;
        load_use_stall = 1'b0;
        case (w_mode)
            MODE_RESET: begin
                pc_write     = 1'b0;
                if_id_write  = 1'b0;
                id_ex_bubble = 1'b1;
                if_id_flush  = 1'b1;
            end
            MODE_FREEZE: begin
                pc_write    = 1'b0;
                if_id_write = 1'b0;
            end
            MODE_FLUSH: begin
                // The fetch redirect must proceed, so the enables stay high.
                // Both the ID instruction and the wrong-path fetch are killed.
                id_ex_bubble = 1'b1;
                if_id_flush  = 1'b1;
            end
            MODE_HAZARD: begin
                pc_write       = 1'b0;
                if_id_write    = 1'b0;
                id_ex_bubble   = 1'b1;
                load_use_stall = 1'b1;
            end
            default: begin
                pc_write    = 1'b1;
                if_id_write = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Scoreboard entries. x0 is hard-wired to zero so it can never stall.
    // ------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_entry
            if (gi == 0) begin : g_zero
                assign r_cnt[gi] = '0;
            end else begin : g_live
                always_ff @(posedge clk) begin
                    if (!rst_n) begin
                        r_cnt[gi] <= '0;
                    end else if (!mem_stall) begin
                        // A new issue to this register replaces any older
                        // count that is still running.
                        if (w_issue && (id_rd == REG_AW'(gi))) begin
                            r_cnt[gi] <= c_LOAD_CNT;
                        end else if (r_cnt[gi] != '0) begin
                            r_cnt[gi] <= r_cnt[gi] - c_CNT_ONE;
                        end
                    end
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Stall-cycle performance counter, saturating at all-ones.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stall_count <= '0;
        end else if (load_use_stall && (r_stall_count != c_PERF_MAX)) begin
            r_stall_count <= r_stall_count + c_PERF_ONE;
        end
    end

    assign stall_count = r_stall_count;

endmodule
`default_nettype wire

// File: tb/tb_load_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_load_hazard_scoreboard
// Description : Self-checking bench for load_hazard_scoreboard. Three instances
//               share one stimulus bus:
//                 DUT0: LOAD_LATENCY=1, PERF_W=16
//                 DUT1: LOAD_LATENCY=3, PERF_W=16
//                 DUT2: LOAD_LATENCY=2, PERF_W=2
//               A reference model tracks, per register, the pipeline time at
//               which a load result becomes forwardable. That time advances
//               only on non-frozen edges.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_load_hazard_scoreboard;

    localparam int NDUT = 3;
    localparam int LL   [NDUT] = '{1, 3, 2};
    localparam int SMAX [NDUT] = '{65535, 65535, 3};

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid, id_uses_rs1, id_uses_rs2, id_is_load;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       ex_branch_taken, mem_stall;

    wire [NDUT-1:0] pcw, ifw, bub, fl, lus;
    wire [15:0]     sc0, sc1;
    wire [1:0]      sc2;

    always #5 clk = ~clk;

    load_hazard_scoreboard #(.NUM_REGS(32), .REG_AW(5), .LOAD_LATENCY(1), .PERF_W(16)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_is_load(id_is_load),
        .id_rd(id_rd), .ex_branch_taken(ex_branch_taken), .mem_stall(mem_stall),
        .pc_write(pcw[0]), .if_id_write(ifw[0]), .id_ex_bubble(bub[0]), .if_id_flush(fl[0]),
        .load_use_stall(lus[0]), .stall_count(sc0));

    load_hazard_scoreboard #(.NUM_REGS(32), .REG_AW(5), .LOAD_LATENCY(3), .PERF_W(16)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_is_load(id_is_load),
        .id_rd(id_rd), .ex_branch_taken(ex_branch_taken), .mem_stall(mem_stall),
        .pc_write(pcw[1]), .if_id_write(ifw[1]), .id_ex_bubble(bub[1]), .if_id_flush(fl[1]),
        .load_use_stall(lus[1]), .stall_count(sc1));

    load_hazard_scoreboard #(.NUM_REGS(32), .REG_AW(5), .LOAD_LATENCY(2), .PERF_W(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_is_load(id_is_load),
        .id_rd(id_rd), .ex_branch_taken(ex_branch_taken), .mem_stall(mem_stall),
        .pc_write(pcw[2]), .if_id_write(ifw[2]), .id_ex_bubble(bub[2]), .if_id_flush(fl[2]),
        .load_use_stall(lus[2]), .stall_count(sc2));

    // ------------------------------------------------------------------------
    // Bookkeeping
    // ------------------------------------------------------------------------
    int checks = 0;
    int passes = 0;
    int fails  = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passes++;
        else begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Reference model. Outputs are packed as {pc_write, if_id_write,
    // id_ex_bubble, if_id_flush, load_use_stall}.
    // ------------------------------------------------------------------------
    longint ready_at [NDUT][32];
    longint tnow     [NDUT];
    int     mcount   [NDUT];
    bit     model_valid = 1'b0;
    logic   smp_lus  [NDUT];

    function automatic bit busy(input int d, input logic [4:0] r);
        return (r != 5'd0) && (tnow[d] < ready_at[d][r]);
    endfunction

    function automatic logic [4:0] model_out(input int d);
        bit hz;
        if (!rst_n)          return 5'b00110;
        if (mem_stall)       return 5'b00000;
        if (ex_branch_taken) return 5'b11110;
        hz = id_valid && ((id_uses_rs1 && busy(d, id_rs1)) || (id_uses_rs2 && busy(d, id_rs2)));
        if (hz)              return 5'b00101;
        return 5'b11000;
    endfunction

    function automatic logic [4:0] dut_vec(input int d);
        return {pcw[d], ifw[d], bub[d], fl[d], lus[d]};
    endfunction

    function automatic int dut_sc(input int d);
        case (d)
            0:       return int'(sc0);
            1:       return int'(sc1);
            default: return int'(sc2);
        endcase
    endfunction

    task automatic check_model();
        for (int d = 0; d < NDUT; d++) begin
            check($sformatf("ctrl_dut%0d", d), dut_vec(d), model_out(d));
            if (model_valid) check($sformatf("stall_count_dut%0d", d), dut_sc(d), mcount[d]);
            smp_lus[d] = lus[d];
        end
    endtask

    task automatic update_model();
        for (int d = 0; d < NDUT; d++) begin
            logic [4:0] o;
            o = model_out(d);
            if (!rst_n) begin
                for (int r = 0; r < 32; r++) ready_at[d][r] = 0;
                mcount[d] = 0;
            end else if (!mem_stall) begin
                if (o[0] && mcount[d] < SMAX[d]) mcount[d]++;
                if (o == 5'b11000 && id_valid && id_is_load && id_rd != 5'd0)
                    ready_at[d][id_rd] = tnow[d] + LL[d] + 1;
                tnow[d]++;
            end
        end
        model_valid = 1'b1;
    endtask

    task automatic cycle();
        @(negedge clk);
        check_model();
        @(posedge clk);
        update_model();
        #1;
    endtask

    // ------------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------------
    task automatic set_in(input logic rn, input logic v, input logic [4:0] r1, input logic [4:0] r2,
                          input logic u1, input logic u2, input logic ld, input logic [4:0] rd,
                          input logic br, input logic ms);
        rst_n = rn; id_valid = v; id_rs1 = r1; id_rs2 = r2; id_uses_rs1 = u1;
        id_uses_rs2 = u2; id_is_load = ld; id_rd = rd; ex_branch_taken = br; mem_stall = ms;
    endtask

    task automatic set_idle();            set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
    task automatic set_load(input logic [4:0] rd);   set_in(1, 1, 0, 0, 1, 0, 1, rd, 0, 0); endtask
    task automatic set_reader(input logic [4:0] rs); set_in(1, 1, rs, rs, 1, 1, 0, 5'd20, 0, 0); endtask

    // Holds a reader of rs in ID until DUT d stops stalling; returns stall cycles.
    task automatic consume(input int d, input logic [4:0] rs, output int n);
        bit done;
        done = 1'b0;
        n = 0;
        for (int k = 0; k < 20 && !done; k++) begin
            set_reader(rs);
            cycle();
            if (smp_lus[d]) n++;
            else done = 1'b1;
        end
        check($sformatf("consume_bounded_dut%0d", d), done, 1);
    endtask

    // ------------------------------------------------------------------------
    // Directed vector table for DUT0 (LOAD_LATENCY=1)
    // ------------------------------------------------------------------------
    typedef struct {
        logic       rn, v;
        logic [4:0] r1, r2;
        logic       u1, u2, ld;
        logic [4:0] rd;
        logic       br, ms;
        logic [4:0] exp_ctrl;
        int         exp_sc;
    } vec_t;

    localparam int NVEC = 16;
    vec_t tbl [NVEC];

    initial begin
        int n;

        //            rn v  r1 r2 u1 u2 ld rd br ms  ctrl      sc
        tbl[0]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00110, 0}; // reset held
        tbl[1]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11000, 0}; // idle
        tbl[2]  = '{1, 1, 2, 0, 1, 0, 1, 5, 0, 0, 5'b11000, 0}; // lw x5
        tbl[3]  = '{1, 1, 5, 1, 1, 1, 0, 6, 0, 0, 5'b00101, 0}; // add x6,x5,x1 stalls
        tbl[4]  = '{1, 1, 5, 1, 1, 1, 0, 6, 0, 0, 5'b11000, 1}; // add proceeds
        tbl[5]  = '{1, 1, 0, 0, 1, 0, 1, 0, 0, 0, 5'b11000, 1}; // lw x0
        tbl[6]  = '{1, 1, 0, 0, 1, 1, 0, 3, 0, 0, 5'b11000, 1}; // reader of x0
        tbl[7]  = '{1, 1, 0, 0, 1, 0, 1, 9, 0, 0, 5'b11000, 1}; // lw x9
        tbl[8]  = '{1, 1, 3, 9, 1, 0, 0, 4, 0, 0, 5'b11000, 1}; // rs2=x9 but unused
        tbl[9]  = '{1, 1, 5, 0, 1, 0, 1, 5, 0, 0, 5'b11000, 1}; // lw x5,0(x5)
        tbl[10] = '{1, 1, 5, 0, 1, 0, 1, 7, 1, 0, 5'b11110, 1}; // hazard + branch: flush
        tbl[11] = '{1, 1, 7, 7, 1, 1, 0, 8, 0, 0, 5'b11000, 1}; // x7 never claimed
        tbl[12] = '{1, 1, 0, 0, 1, 0, 1, 4, 0, 0, 5'b11000, 1}; // lw x4
        tbl[13] = '{1, 1, 4, 4, 1, 1, 0, 8, 0, 1, 5'b00000, 1}; // frozen
        tbl[14] = '{1, 1, 4, 4, 1, 1, 0, 8, 0, 0, 5'b00101, 1}; // stall after freeze
        tbl[15] = '{1, 1, 4, 4, 1, 1, 0, 8, 0, 0, 5'b11000, 2}; // proceeds

        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle();

        for (int i = 0; i < NVEC; i++) begin
            set_in(tbl[i].rn, tbl[i].v, tbl[i].r1, tbl[i].r2, tbl[i].u1, tbl[i].u2,
                   tbl[i].ld, tbl[i].rd, tbl[i].br, tbl[i].ms);
            @(negedge clk);
            check_model();
            check($sformatf("tbl%0d_ctrl", i), dut_vec(0), tbl[i].exp_ctrl);
            check($sformatf("tbl%0d_sc", i), sc0, tbl[i].exp_sc);
            @(posedge clk);
            update_model();
            #1;
        end

        // LOAD_LATENCY=3: lw x7; nop; sub x8,x7,x7 -> 2 stalls; distance 4 -> none.
        repeat (4) begin set_idle(); cycle(); end
        set_load(5'd7); cycle();
        set_idle();     cycle();
        consume(1, 5'd7, n);
        check("ll3_distance2_stalls", n, 2);
        set_load(5'd7); cycle();
        repeat (3) begin set_idle(); cycle(); end
        consume(1, 5'd7, n);
        check("ll3_distance4_stalls", n, 0);

        // LOAD_LATENCY=2 with a 4-cycle memory freeze over the pending hazard.
        repeat (4) begin set_idle(); cycle(); end
        set_load(5'd10); cycle();
        for (int k = 0; k < 4; k++) begin
            set_reader(5'd10);
            mem_stall = 1'b1;
            cycle();
            check("freeze_enables_dut2", dut_vec(2), 0);
        end
        consume(2, 5'd10, n);
        check("ll2_after_freeze_stalls", n, 2);

        // PERF_W=2 saturation, then reset in the middle of a stall.
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); cycle();
        check("sc2_after_reset", sc2, 0);
        set_load(5'd11); cycle();
        consume(2, 5'd11, n);
        check("sc2_pair1_stalls", n, 2);
        check("sc2_after_2", sc2, 2);
        set_load(5'd12); cycle();
        consume(2, 5'd12, n);
        set_load(5'd13); cycle();
        consume(2, 5'd13, n);
        check("sc2_saturated", sc2, 3);
        set_load(5'd14);   cycle();
        set_reader(5'd14); cycle();
        check("midstall_stalling", smp_lus[2], 1);
        set_reader(5'd14); rst_n = 1'b0; cycle();
        check("sc2_cleared_by_reset", sc2, 0);
        set_reader(5'd14); cycle();
        check("no_hazard_after_reset", smp_lus[2], 0);

        // Randomized traffic against the model.
        for (int k = 0; k < 400; k++) begin
            set_in(($urandom_range(0, 63) != 0), ($urandom_range(0, 7) != 0),
                   5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                   1'($urandom), 1'($urandom), ($urandom_range(0, 2) == 0),
                   5'($urandom_range(0, 7)), ($urandom_range(0, 7) == 0),
                   ($urandom_range(0, 7) == 0));
            cycle();
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    // Absolute watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", passes, checks);
        $fatal(1);
    end

endmodule
`default_nettype wire
